// File: rtl/keccak_pkg.sv
// Shared constants and types for the SHAKE128 absorb front end.
package keccak_pkg;

   localparam int LANE_W     = 64;
   localparam int RATE_BITS  = 1344;
   localparam int RATE_LANES = 21;

   localparam logic [7:0] SHAKE_DS = 8'h1F;
   localparam logic [7:0] PAD_END  = 8'h80;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_HOLD,
      ST_XPAD
   } absorb_state_t;

endpackage

// File: rtl/pad_lane_gen.sv
// Combinational lane formatter: masks the unused bytes of the final message
// word and drops the SHAKE domain byte right after the last valid byte.
// spill flags a full final word, whose domain byte must go into the next lane.
module pad_lane_gen
   import keccak_pkg::*;
(
   input  logic [LANE_W-1:0] in_data,
   input  logic [3:0]        in_bytes,
   input  logic              in_last,
   output logic [LANE_W-1:0] lane,
   output logic              spill
);

   logic [3:0] nbytes;

   // Clamp the byte count, zero bytes past it and insert the domain byte.
   always_comb begin
      nbytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
      spill  = in_last && (nbytes == 4'd8);
      lane   = in_data;
      if (in_last) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) >= nbytes) begin
               lane[8*i +: 8] = 8'h00;
            end
            if (4'(i) == nbytes) begin
               lane[8*i +: 8] = SHAKE_DS;
            end
         end
      end
   end

endmodule

// File: rtl/absorb_sipo_pad.sv
// SHAKE128 absorb front end: gathers 64-bit words into a 1344-bit rate block,
// applies the 0x1F ... 0x80 padding and hands blocks downstream on valid/ready.
// Word k of a block sits at [RATE-1-64k -: 64], so lane 0 is the top lane.
module absorb_sipo_pad
   import keccak_pkg::*;
#(
   parameter int DATA_SIZE = LANE_W,
   parameter int RATE      = RATE_BITS,
   parameter int LANES     = RATE_LANES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_last,
   input  logic [3:0]           in_bytes,
   output logic                 blk_valid,
   input  logic                 blk_ready,
   output logic [RATE-1:0]      blk_data,
   output logic                 blk_last
);

   localparam int CNT_W = $clog2(LANES);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   absorb_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [0:LANES-1][DATA_SIZE-1:0] blk_q, blk_d;
   logic last_q, last_d;
   logic pend_q, pend_d;

   logic [DATA_SIZE-1:0] pad_lane;
   logic                 pad_spill;

   pad_lane_gen u_pad_lane_gen (
      .in_data  (in_data),
      .in_bytes (in_bytes),
      .in_last  (in_last),
      .lane     (pad_lane),
      .spill    (pad_spill)
   );

   assign in_ready  = rst && (state_q == ST_FILL);
   assign blk_valid = (state_q == ST_HOLD);
   assign blk_last  = last_q;
   assign blk_data  = blk_q;

   // State, lane counter, block buffer and flags; reset drops any partial block.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         blk_q   <= '0;
         last_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state logic: fill lanes, pad on the last word, hold for handoff,
   // and build a padding-only block when the message exactly filled a block.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      last_d  = last_q;
      pend_d  = pend_q;
      unique case (state_q)
         ST_FILL: begin
            if (in_valid && in_ready) begin
               blk_d[cnt_q] = pad_lane;
               cnt_d        = cnt_q + CNT_W'(1);
               if (!in_last) begin
                  if (cnt_q == LAST_LANE) begin
                     state_d = ST_HOLD;
                     last_d  = 1'b0;
                  end
               end else if (!pad_spill) begin
                  blk_d[LANES-1][DATA_SIZE-1] = 1'b1;
                  state_d = ST_HOLD;
                  last_d  = 1'b1;
               end else if (cnt_q != LAST_LANE) begin
                  blk_d[cnt_q + CNT_W'(1)]    = DATA_SIZE'(SHAKE_DS);
                  blk_d[LANES-1][DATA_SIZE-1] = 1'b1;
                  state_d = ST_HOLD;
                  last_d  = 1'b1;
               end else begin
                  state_d = ST_HOLD;
                  last_d  = 1'b0;
                  pend_d  = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (blk_ready) begin
               blk_d   = '0;
               cnt_d   = '0;
               last_d  = 1'b0;
               state_d = pend_q ? ST_XPAD : ST_FILL;
            end
         end
         ST_XPAD: begin
            blk_d[0]       = DATA_SIZE'(SHAKE_DS);
            blk_d[LANES-1] = {PAD_END, {(DATA_SIZE-8){1'b0}}};
            pend_d  = 1'b0;
            last_d  = 1'b1;
            state_d = ST_HOLD;
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

endmodule
